ahb_lite_burst_master: RTL and testbench

- Parametrised AHB-Lite bus master. Accepts one command (address, direction, size, burst type, length) over a valid/ready handshake and executes it as a pipelined AHB-Lite transfer sequence.
- Generalises the existing single/INCR master:
  - configurable data and address width;
  - fixed-length INCR4/8/16 and WRAP4/8/16 bursts;
  - 1 KB boundary splitting for undefined INCR;
  - BUSY insertion on write-data starvation;
  - two-cycle ERROR abort.
- Sits between a local engine (DMA or CPU bridge) and the AHB-Lite interconnect.

---
 rtl/ahb_lite_burst_master.sv | 175 +++++++++++++++++
 tb/tb_ahb_lite_burst_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_burst_master.sv
// AHB-Lite burst master: runs one command as a pipelined SINGLE/INCR/INCRn/WRAPn
// transfer sequence, with BUSY on write-data starvation and two-cycle ERROR abort.
module ahb_lite_burst_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [1:0]        HTRANS,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA
);
  localparam int MAX_SIZE = $clog2(DATA_W/8);
  localparam int CNT_W    = (LEN_W > 5) ? LEN_W : 5;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_INCR = 3'd1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DLAST, S_ERR1, S_ERR2} state_t;
  state_t state, state_n;

  logic [CNT_W-1:0]  cnt, cmd_beats;
  logic [12:0]       fix_beats, span;
  logic [ADDR_W-1:0] bytes, wmask, next_addr;
  logic [2:0]        wsh;
  logic              first, dp_valid, is_wrap;
  logic              reject, start, accept, dp_err, rd_cap, done_n, err_n;

  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign cmd_ready = (state == S_IDLE);

  // Command decode and same-cycle legality check
  always_comb begin
    cmd_beats = CNT_W'(16);
    fix_beats = 13'd16;
    case (cmd_burst)
      3'd0:       begin cmd_beats = CNT_W'(1); fix_beats = 13'd0; end
      3'd1:       begin cmd_beats = (cmd_len == '0) ? CNT_W'(1) : CNT_W'(cmd_len); fix_beats = 13'd0; end
      3'd2, 3'd3: begin cmd_beats = CNT_W'(4); fix_beats = 13'd4; end
      3'd4, 3'd5: begin cmd_beats = CNT_W'(8); fix_beats = 13'd8; end
      default:    begin cmd_beats = CNT_W'(16); fix_beats = 13'd16; end
    endcase
  end

  assign span   = {3'b000, cmd_addr[9:0]} + (fix_beats << cmd_size);
  assign reject = (cmd_size > 3'(MAX_SIZE)) ||
                  ((cmd_addr & ~({ADDR_W{1'b1}} << cmd_size)) != '0) ||
                  (cmd_burst[0] && (cmd_burst != B_INCR) && (span > 13'd1024));
  assign start  = (state == S_IDLE) && cmd_valid && !reject;

  // Next beat address: linear step, or wrap inside an n*bytes window
  always_comb begin
    wsh = 3'd4;
    case (HBURST)
      3'd2:    wsh = 3'd2;
      3'd4:    wsh = 3'd3;
      default: wsh = 3'd4;
    endcase
  end

  assign is_wrap   = !HBURST[0] && (HBURST != 3'd0);
  assign bytes     = ADDR_W'(1) << HSIZE;
  assign wmask     = (bytes << wsh) - ADDR_W'(1);
  assign next_addr = is_wrap ? ((HADDR & ~wmask) | ((HADDR + bytes) & wmask)) : (HADDR + bytes);

  // Starved writes park the bus: IDLE before the first beat, BUSY mid-burst
  always_comb begin
    HTRANS = T_IDLE;
    if (state == S_ADDR) begin
      if (HWRITE && !wr_valid)
        HTRANS = first ? T_IDLE : T_BUSY;
      else if (first || (HBURST == B_INCR && HADDR[9:0] == 10'd0))
        HTRANS = T_NONSEQ;
      else
        HTRANS = T_SEQ;
    end
  end

  assign dp_err   = dp_valid && HRESP;
  assign accept   = (state == S_ADDR) && HREADY && HTRANS[1] && !dp_err;
  assign wr_ready = accept && HWRITE;
  assign rd_cap   = ((state == S_ADDR) || (state == S_DLAST)) && dp_valid && !HWRITE && HREADY && !HRESP;

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE:
        if (cmd_valid) begin
          if (reject) begin done_n = 1'b1; err_n = 1'b1; end
          else state_n = S_ADDR;
        end
      S_ADDR, S_DLAST:
        if (dp_err) begin
          // single-cycle error response is a protocol violation: finish as error
          if (HREADY) begin state_n = S_ERR2; done_n = 1'b1; err_n = 1'b1; end
          else state_n = S_ERR1;
        end else if (state == S_ADDR) begin
          if (accept && cnt == CNT_W'(1)) state_n = S_DLAST;
        end else if (HREADY) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      S_ERR1:
        if (HREADY && HRESP) begin state_n = S_ERR2; done_n = 1'b1; err_n = 1'b1; end
      S_ERR2:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_n;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HSIZE    <= 3'd0;
      HBURST   <= 3'd0;
      HWDATA   <= '0;
      cnt      <= '0;
      first    <= 1'b0;
      dp_valid <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= done_n;
      err      <= err_n;
      rd_valid <= rd_cap;
      if (rd_cap) rd_data <= HRDATA;
      if (HREADY) dp_valid <= accept;
      if (start) begin
        HADDR  <= cmd_addr;
        HWRITE <= cmd_write;
        HSIZE  <= cmd_size;
        HBURST <= cmd_burst;
        cnt    <= cmd_beats;
        first  <= 1'b1;
      end
      if (accept) begin
        cnt   <= cnt - CNT_W'(1);
        first <= 1'b0;
        if (HWRITE) HWDATA <= wr_data;
        if (cnt != CNT_W'(1)) HADDR <= next_addr;
      end
    end
  end
endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Bench for ahb_lite_burst_master: scenario tasks drive a reactive AHB slave and
// compare bus beats, write data, read data and completion against a beat-list model.
module tb_ahb_lite_burst_master;
  localparam int DATA_W = 32, ADDR_W = 32, LEN_W = 5;

  logic HCLK_tb = 1'b0;
  logic HRESETn_tb;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0] cmd_size, cmd_burst;
  logic [LEN_W-1:0] cmd_len;
  logic wr_valid, wr_ready, rd_valid, done, err;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [ADDR_W-1:0] HADDR;
  logic HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;
  logic [1:0] HTRANS;
  logic [DATA_W-1:0] HWDATA, HRDATA;

  int checks = 0, failures = 0;
  int res_lat, res_busy, res_acc;
  logic [31:0] wq [32];
  logic [31:0] rq [32];

  always #5 HCLK_tb = ~HCLK_tb;

  ahb_lite_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .HCLK(HCLK_tb), .HRESETn(HRESETn_tb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  function automatic int nbeats(int burst, int len);
    if (burst == 0) return 1;
    if (burst == 1) return (len == 0) ? 1 : len;
    return 4 << ((burst >> 1) - 1);
  endfunction

  function automatic logic [31:0] beat_addr(logic [31:0] a, int burst, int size, int n, int i);
    logic [31:0] bytes, span, base;
    bytes = 32'd1 << size;
    if (burst == 2 || burst == 4 || burst == 6) begin
      span = bytes * n;
      base = a - (a % span);
      return base + ((a - base + bytes * i) % span);
    end
    return a + bytes * i;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 32; i++) begin wq[i] = $urandom; rq[i] = $urandom; end
  endtask

  // One command end to end; the slave reacts to the DUT each cycle
  task automatic run_cmd(input logic [31:0] a, input bit wr, input int size, input int burst,
                         input int len, input int err_beat, input int wait_beat,
                         input int starve_beat, input int starve_cyc,
                         input int wait_pct, input int starve_pct);
    int n, exp_acc, exp_wr, exp_rd;
    bit rej, has_err, exp_err;
    int acc, wr_cnt, rd_cnt, wr_next, starve_left, err_stage, dp_idx;
    bit dp_act, consumed, waited, done_seen, prev_hready, prev_hresp;
    logic [1:0] prev_htrans, exp_tr;
    logic [31:0] prev_haddr, prev_hwdata, ea;
    n = nbeats(burst, len);
    rej = (size > 2) || ((a % (32'd1 << size)) != 0) ||
          ((burst == 3 || burst == 5 || burst == 7) && ((a % 1024) + n * (1 << size)) > 1024);
    has_err = !rej && err_beat >= 0 && err_beat < n;
    exp_acc = rej ? 0 : (has_err ? err_beat + 1 : n);
    exp_wr  = (wr && !rej) ? exp_acc : 0;
    exp_rd  = (wr || rej) ? 0 : (has_err ? err_beat : n);
    exp_err = rej || has_err;
    acc = 0; wr_cnt = 0; rd_cnt = 0; wr_next = 0; starve_left = 0; err_stage = 0; dp_idx = 0;
    dp_act = 0; consumed = 0; waited = 0; done_seen = 0; prev_hready = 1; prev_hresp = 0;
    prev_htrans = 2'b00; prev_haddr = '0; prev_hwdata = '0;
    res_busy = 0; res_lat = -1;

    @(negedge HCLK_tb);
    cmd_valid = 1; cmd_addr = a; cmd_write = wr; cmd_size = 3'(size); cmd_burst = 3'(burst);
    cmd_len = LEN_W'(len); wr_valid = 0; HREADY = 1; HRESP = 0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready got=%b want=1", cmd_ready); end

    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge HCLK_tb);
      cmd_valid = 0;
      if (wr && !rej) begin
        if (consumed) begin
          if (wr_next == starve_beat) starve_left = starve_cyc;
          wr_next++;
          wr_valid = 0;
        end
        if (!wr_valid && wr_next < n) begin
          if (starve_left > 0) starve_left--;
          else if ($urandom_range(99) >= starve_pct) begin wr_valid = 1; wr_data = wq[wr_next]; end
        end
      end
      HRESP = 0; HRDATA = $urandom; HREADY = 1;
      if (dp_act && dp_idx == err_beat) begin
        HRESP = 1; HREADY = (err_stage == 1);
      end else if (dp_act) begin
        HRDATA = rq[dp_idx];
        if (dp_idx == wait_beat && !waited) begin HREADY = 0; waited = 1; end
        else if ($urandom_range(99) < wait_pct) HREADY = 0;
      end
      #1;
      if (!prev_hready && !prev_hresp) begin
        checks++;
        if (HADDR !== prev_haddr || HWDATA !== prev_hwdata || (prev_htrans[1] && HTRANS !== prev_htrans)) begin
          failures++;
          $display("FAIL freeze got HADDR=%h HWDATA=%h HTRANS=%0d want HADDR=%h HWDATA=%h HTRANS=%0d",
                   HADDR, HWDATA, HTRANS, prev_haddr, prev_hwdata, prev_htrans);
        end
      end
      if (HTRANS == 2'b01) res_busy++;
      if (dp_act && HREADY) begin
        if (!HRESP && wr) begin
          checks++;
          if (HWDATA !== wq[dp_idx]) begin
            failures++; $display("FAIL hwdata beat=%0d got=%h want=%h", dp_idx, HWDATA, wq[dp_idx]);
          end
        end
        dp_act = 0;
      end
      if (dp_act && dp_idx == err_beat && !HREADY) err_stage = 1;
      if (HREADY && HTRANS[1]) begin
        ea = beat_addr(a, burst, size, n, acc);
        exp_tr = (acc == 0 || (burst == 1 && (ea % 1024) == 0)) ? 2'b10 : 2'b11;
        checks++;
        if (acc >= exp_acc || HADDR !== ea || HTRANS !== exp_tr || HBURST !== 3'(burst) ||
            HSIZE !== 3'(size) || HWRITE !== wr) begin
          failures++;
          $display("FAIL addr_phase beat=%0d got HADDR=%h HTRANS=%0d HBURST=%0d want HADDR=%h HTRANS=%0d HBURST=%0d (beats allowed %0d)",
                   acc, HADDR, HTRANS, HBURST, ea, exp_tr, burst, exp_acc);
        end
        dp_act = 1; dp_idx = acc; acc++;
      end
      consumed = wr_ready;
      if (wr_ready) begin
        wr_cnt++;
        checks++;
        if (!wr_valid) begin failures++; $display("FAIL wr_ready_without_valid got=1 want=0"); end
      end
      if (rd_valid) begin
        checks++;
        if (rd_cnt >= exp_rd || rd_data !== rq[rd_cnt]) begin
          failures++; $display("FAIL rd_data idx=%0d got=%h want=%h (expected %0d beats)", rd_cnt, rd_data, rq[rd_cnt], exp_rd);
        end
        rd_cnt++;
      end
      prev_hready = HREADY; prev_hresp = HRESP; prev_htrans = HTRANS;
      prev_haddr = HADDR; prev_hwdata = HWDATA;
      if (done) begin
        done_seen = 1; res_lat = cyc;
        checks++;
        if (err !== exp_err) begin failures++; $display("FAIL err_flag got=%b want=%b", err, exp_err); end
        break;
      end
    end
    wr_valid = 0; HREADY = 1; HRESP = 0;
    res_acc = acc;
    checks++;
    if (!done_seen) begin failures++; $display("FAIL done_timeout got=none want=done within 400 cycles"); end
    checks++;
    if (acc != exp_acc) begin failures++; $display("FAIL beat_count got=%0d want=%0d", acc, exp_acc); end
    checks++;
    if (wr_cnt != exp_wr) begin failures++; $display("FAIL wr_ready_count got=%0d want=%0d", wr_cnt, exp_wr); end
    checks++;
    if (rd_cnt != exp_rd) begin failures++; $display("FAIL rd_valid_count got=%0d want=%0d", rd_cnt, exp_rd); end
    @(negedge HCLK_tb); #1;
    checks++;
    if (cmd_ready !== 1'b1 || HTRANS !== 2'b00 || rd_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL post_idle got cmd_ready=%b HTRANS=%0d rd_valid=%b done=%b want 1 0 0 0", cmd_ready, HTRANS, rd_valid, done);
    end
  endtask

  task automatic test_reset();
    HRESETn_tb = 0; cmd_valid = 0; cmd_addr = '0; cmd_write = 0; cmd_size = 0; cmd_burst = 0;
    cmd_len = '0; wr_valid = 0; wr_data = '0; HREADY = 1; HRESP = 0; HRDATA = '0;
    repeat (3) @(negedge HCLK_tb);
    #1;
    checks++;
    if (HTRANS !== 2'b00 || HADDR !== '0 || HWDATA !== '0 || HSIZE !== 3'd0 || HBURST !== 3'd0 ||
        HWRITE !== 1'b0 || cmd_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_state got HTRANS=%0d HADDR=%h cmd_ready=%b done=%b err=%b want all zero and cmd_ready=1",
               HTRANS, HADDR, cmd_ready, done, err);
    end
    checks++;
    if (HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
      failures++; $display("FAIL constants got HPROT=%b HMASTLOCK=%b want 0011 0", HPROT, HMASTLOCK);
    end
    @(negedge HCLK_tb); HRESETn_tb = 1;
    @(negedge HCLK_tb); #1;
    checks++;
    if (cmd_ready !== 1'b1 || HTRANS !== 2'b00) begin
      failures++; $display("FAIL after_reset got cmd_ready=%b HTRANS=%0d want 1 0", cmd_ready, HTRANS);
    end
  endtask

  task automatic test_incr4_write();
    fill_rand();
    run_cmd(32'h20, 1, 2, 3, 0, -1, -1, -1, 0, 0, 0);
    checks++;
    if (res_lat != 6) begin failures++; $display("FAIL incr4_latency got=%0d want=6", res_lat); end
    checks++;
    if (res_busy != 0) begin failures++; $display("FAIL incr4_busy got=%0d want=0", res_busy); end
  endtask

  task automatic test_wrap4_read();
    fill_rand();
    rq[0] = 32'h5C; rq[1] = 32'h60; rq[2] = 32'h64; rq[3] = 32'h68;
    run_cmd(32'h38, 0, 2, 2, 0, -1, -1, -1, 0, 0, 0);
    checks++;
    if (res_lat != 6) begin failures++; $display("FAIL wrap4_latency got=%0d want=6", res_lat); end
  endtask

  task automatic test_incr_1k();
    fill_rand();
    run_cmd(32'h3F8, 0, 2, 1, 3, -1, -1, -1, 0, 0, 0);
    checks++;
    if (res_acc != 3) begin failures++; $display("FAIL incr_1k_beats got=%0d want=3", res_acc); end
  endtask

  task automatic test_busy_wait();
    fill_rand();
    run_cmd(32'h100, 1, 2, 3, 0, -1, 1, 0, 2, 0, 0);
    checks++;
    if (res_busy != 2) begin failures++; $display("FAIL busy_cycles got=%0d want=2", res_busy); end
    checks++;
    if (res_lat != 9) begin failures++; $display("FAIL busy_latency got=%0d want=9", res_lat); end
  endtask

  task automatic test_error_abort();
    fill_rand();
    run_cmd(32'h200, 0, 2, 5, 0, 1, -1, -1, 0, 0, 0);
    checks++;
    if (res_lat != 5) begin failures++; $display("FAIL error_latency got=%0d want=5", res_lat); end
  endtask

  task automatic test_reject();
    fill_rand();
    run_cmd(32'h3F0, 0, 2, 7, 0, -1, -1, -1, 0, 0, 0);
    checks++;
    if (res_lat != 1) begin failures++; $display("FAIL reject_cross_latency got=%0d want=1", res_lat); end
    run_cmd(32'h22, 1, 2, 0, 0, -1, -1, -1, 0, 0, 0);
    checks++;
    if (res_lat != 1) begin failures++; $display("FAIL reject_align_latency got=%0d want=1", res_lat); end
    run_cmd(32'h40, 0, 3, 1, 4, -1, -1, -1, 0, 0, 0);
    checks++;
    if (res_lat != 1) begin failures++; $display("FAIL reject_size_latency got=%0d want=1", res_lat); end
  endtask

  task automatic test_reset_mid();
    fill_rand();
    @(negedge HCLK_tb);
    cmd_valid = 1; cmd_addr = 32'h40; cmd_write = 1; cmd_size = 3'd2; cmd_burst = 3'd5; cmd_len = '0;
    wr_valid = 1; wr_data = wq[0]; HREADY = 1; HRESP = 0;
    @(negedge HCLK_tb); cmd_valid = 0;
    @(negedge HCLK_tb);
    @(negedge HCLK_tb); #1;
    checks++;
    if (HTRANS !== 2'b11 || HADDR !== 32'h48) begin
      failures++; $display("FAIL mid_burst got HTRANS=%0d HADDR=%h want 3 00000048", HTRANS, HADDR);
    end
    #2 HRESETn_tb = 0;
    #1;
    checks++;
    if (HTRANS !== 2'b00 || HADDR !== '0 || HWDATA !== '0 || HSIZE !== 3'd0 || HBURST !== 3'd0 ||
        HWRITE !== 1'b0 || cmd_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got HTRANS=%0d HADDR=%h HWDATA=%h cmd_ready=%b wr_ready=%b want 0 0 0 1 0",
               HTRANS, HADDR, HWDATA, cmd_ready, wr_ready);
    end
    @(negedge HCLK_tb); HRESETn_tb = 1; wr_valid = 0;
    @(negedge HCLK_tb); #1;
    checks++;
    if (HTRANS !== 2'b00 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL post_reset got HTRANS=%0d cmd_ready=%b done=%b want 0 1 0", HTRANS, cmd_ready, done);
    end
  endtask

  task automatic test_random();
    int burst, size, len, n, eb;
    logic [31:0] a;
    bit wr;
    for (int k = 0; k < 60; k++) begin
      fill_rand();
      burst = $urandom_range(7);
      size  = ($urandom_range(9) == 0) ? 3 : $urandom_range(2);
      len   = $urandom_range(31);
      a     = $urandom_range(4095);
      if ($urandom_range(9) != 0) a = a & ~((32'd1 << size) - 1);
      wr    = $urandom_range(1);
      n     = nbeats(burst, len);
      eb    = ($urandom_range(5) == 0) ? $urandom_range(n - 1) : -1;
      run_cmd(a, wr, size, burst, len, eb, -1, -1, 0, 25, 30);
    end
  endtask

  initial begin
    test_reset();
    test_incr4_write();
    test_wrap4_read();
    test_incr_1k();
    test_busy_wait();
    test_error_abort();
    test_reject();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
